// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI access sequencer.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4
  } hpi_state_e;

  // HPI register selects driven on hpi_addr.
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  function automatic logic [1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
module hpi_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] grant_o
);

  logic last_q;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant_en_i && (|req_i)) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/hpi_access_sequencer.sv
// Sequences HPI bus accesses to a CY7C67200 for two requesters, and owns the
// chip reset and interrupt synchronizer. Every output comes straight from a flop.
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int RST_CYC    = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_rst,
  input  logic [1:0]  rq_valid,
  input  logic [1:0]  rq_write,
  input  logic [3:0]  rq_addr,
  input  logic [31:0] rq_wdata,
  output logic [1:0]  rq_ready,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        irq,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_o,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_i,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic        hpi_rst_n,
  input  logic        hpi_int
);

  localparam logic [15:0] RST_LAST    = 16'(RST_CYC - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYC - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYC - 1);

  hpi_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        owner_q, owner_d;
  logic [1:0]  rq_ready_q, rq_ready_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        busy_q, busy_d;
  logic [1:0]  hpi_addr_q, hpi_addr_d;
  logic [15:0] hpi_data_o_q, hpi_data_o_d;
  logic        hpi_data_oe_q, hpi_data_oe_d;
  logic        hpi_cs_n_q, hpi_cs_n_d;
  logic        hpi_rd_n_q, hpi_rd_n_d;
  logic        hpi_wr_n_q, hpi_wr_n_d;
  logic        hpi_rst_n_q, hpi_rst_n_d;
  logic        int_meta_q, int_sync_q;

  logic        grant_en;
  logic [1:0]  grant;
  logic        gidx;
  logic        in_access;
  logic        rsp_fire;

  hpi_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (rq_valid),
    .grant_en_i (grant_en),
    .grant_o    (grant)
  );

  assign gidx = grant[1];

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_en = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_IDLE: begin
        if (|rq_valid) begin
          grant_en = 1'b1;
          state_d  = ST_SETUP;
          cnt_d    = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // A software reset wins over everything, including an access in flight.
    if (sw_rst) begin
      state_d  = ST_RST_HOLD;
      cnt_d    = '0;
      grant_en = 1'b0;
    end

    write_d      = grant_en ? (gidx ? rq_write[1] : rq_write[0]) : write_q;
    owner_d      = grant_en ? gidx : owner_q;
    hpi_addr_d   = grant_en ? (gidx ? rq_addr[3:2] : rq_addr[1:0]) : hpi_addr_q;
    hpi_data_o_d = (grant_en && write_d) ? (gidx ? rq_wdata[31:16] : rq_wdata[15:0])
                                         : hpi_data_o_q;
    rq_ready_d   = grant_en ? grant : 2'b00;

    // Bus controls are decoded from the next state so they line up with it.
    in_access     = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    hpi_cs_n_d    = !in_access;
    hpi_rd_n_d    = !((state_d == ST_STROBE) && !write_d);
    hpi_wr_n_d    = !((state_d == ST_STROBE) && write_d);
    hpi_data_oe_d = in_access && write_d;
    hpi_rst_n_d   = (state_d != ST_RST_HOLD);
    busy_d        = (state_d != ST_IDLE);

    rsp_fire      = (state_q == ST_STROBE) && (state_d == ST_HOLD);
    rsp_valid_d   = rsp_fire ? idx2onehot(owner_q) : 2'b00;
    rsp_rdata_d   = (rsp_fire && !write_q) ? hpi_data_i : rsp_rdata_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RST_HOLD;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      owner_q       <= 1'b0;
      rq_ready_q    <= 2'b00;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_q   <= '0;
      busy_q        <= 1'b1;
      hpi_addr_q    <= '0;
      hpi_data_o_q  <= '0;
      hpi_data_oe_q <= 1'b0;
      hpi_cs_n_q    <= 1'b1;
      hpi_rd_n_q    <= 1'b1;
      hpi_wr_n_q    <= 1'b1;
      hpi_rst_n_q   <= 1'b0;
      int_meta_q    <= 1'b0;
      int_sync_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      owner_q       <= owner_d;
      rq_ready_q    <= rq_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      busy_q        <= busy_d;
      hpi_addr_q    <= hpi_addr_d;
      hpi_data_o_q  <= hpi_data_o_d;
      hpi_data_oe_q <= hpi_data_oe_d;
      hpi_cs_n_q    <= hpi_cs_n_d;
      hpi_rd_n_q    <= hpi_rd_n_d;
      hpi_wr_n_q    <= hpi_wr_n_d;
      hpi_rst_n_q   <= hpi_rst_n_d;
      int_meta_q    <= hpi_int;
      int_sync_q    <= int_meta_q;
    end
  end

  assign rq_ready    = rq_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = busy_q;
  assign irq         = int_sync_q;
  assign hpi_addr    = hpi_addr_q;
  assign hpi_data_o  = hpi_data_o_q;
  assign hpi_data_oe = hpi_data_oe_q;
  assign hpi_cs_n    = hpi_cs_n_q;
  assign hpi_rd_n    = hpi_rd_n_q;
  assign hpi_wr_n    = hpi_wr_n_q;
  assign hpi_rst_n   = hpi_rst_n_q;

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Directed bench for hpi_access_sequencer: reset hold, write/read timing,
// round-robin order, software-reset abort and interrupt synchronizer latency.
module tb_hpi_access_sequencer;

  logic        clk;
  logic        reset;
  logic        sw_rst;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_write;
  logic [3:0]  rq_addr;
  logic [31:0] rq_wdata;
  logic [1:0]  rq_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        irq;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_o;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_i;
  logic        hpi_cs_n;
  logic        hpi_rd_n;
  logic        hpi_wr_n;
  logic        hpi_rst_n;
  logic        hpi_int;

  int n_checks = 0;
  int n_bad    = 0;
  int excl_viol = 0;

  hpi_access_sequencer #(
    .STROBE_CYC (4),
    .HOLD_CYC   (2),
    .RST_CYC    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_rst      (sw_rst),
    .rq_valid    (rq_valid),
    .rq_write    (rq_write),
    .rq_addr     (rq_addr),
    .rq_wdata    (rq_wdata),
    .rq_ready    (rq_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .irq         (irq),
    .hpi_addr    (hpi_addr),
    .hpi_data_o  (hpi_data_o),
    .hpi_data_oe (hpi_data_oe),
    .hpi_data_i  (hpi_data_i),
    .hpi_cs_n    (hpi_cs_n),
    .hpi_rd_n    (hpi_rd_n),
    .hpi_wr_n    (hpi_wr_n),
    .hpi_rst_n   (hpi_rst_n),
    .hpi_int     (hpi_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read and write strobes must never overlap, and DATA is never driven during a read.
  always @(negedge clk) begin
    if (!reset && !hpi_rd_n && (!hpi_wr_n || hpi_data_oe)) excl_viol++;
  end

  // Nine-sample trace of one access, starting at the IDLE cycle before the grant.
  logic [8:0]  cs_v, wr_v, rd_v, oe_v, busy_v, rdy_v, rsp_v;
  logic [1:0]  rdy_val, rsp_val, addr_mid;
  logic [15:0] data_mid, rdata_at_rsp, rdata_end, rd_inject;

  task automatic window();
    rdy_val = 2'b00;
    rsp_val = 2'b00;
    rdata_at_rsp = 16'h0;
    for (int i = 0; i < 9; i++) begin
      cs_v[i]   = hpi_cs_n;
      wr_v[i]   = hpi_wr_n;
      rd_v[i]   = hpi_rd_n;
      oe_v[i]   = hpi_data_oe;
      busy_v[i] = busy;
      rdy_v[i]  = |rq_ready;
      rsp_v[i]  = |rsp_valid;
      if (rq_ready != 2'b00) begin
        rdy_val  = rq_ready;
        rq_valid = rq_valid & ~rq_ready;
      end
      if (rsp_valid != 2'b00) begin
        rsp_val      = rsp_valid;
        rdata_at_rsp = rsp_rdata;
      end
      if (i == 3) begin
        addr_mid = hpi_addr;
        data_mid = hpi_data_o;
      end
      // Only the value present in the last strobe cycle may be captured.
      hpi_data_i = (i == 5) ? rd_inject : 16'hDEAD;
      if (i < 8) @(negedge clk);
    end
    rdata_end = rsp_rdata;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, busy_bad, rdy_bad, gcnt, idle_cnt, n;
    int gcyc[4];
    logic [1:0] gval[4];

    reset = 1'b1; sw_rst = 1'b0; hpi_int = 1'b0; hpi_data_i = 16'hDEAD;
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr = 4'b0010; rq_wdata = 32'h0000_BEEF;
    rd_inject = 16'hDEAD;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_hpi_rst_n", hpi_rst_n, 0);
    check("rst_strobes", {hpi_cs_n, hpi_rd_n, hpi_wr_n}, 3'b111);
    check("rst_oe_addr_data", {hpi_data_oe, hpi_addr, hpi_data_o}, 19'h0);
    check("rst_busy_irq", {busy, irq}, 2'b10);
    check("rst_rdy_rsp_rdata", {rq_ready, rsp_valid, rsp_rdata}, 20'h0);

    // Chip reset held for RST_CYC cycles after reset release, no grant meanwhile
    reset = 1'b0;
    low = 0; busy_bad = 0; rdy_bad = 0;
    while (hpi_rst_n == 1'b0 && low < 50) begin
      low++;
      if (busy !== 1'b1) busy_bad++;
      if (rq_ready != 2'b00) rdy_bad++;
      @(negedge clk);
    end
    check("rst_low_cycles", low, 8);
    check("busy_in_rst", busy_bad, 0);
    check("no_grant_in_rst", rdy_bad, 0);

    // Requester 0 writes 0xBEEF to register 2
    window();
    check("wr_ready_pulse", rdy_v, 9'b000000010);
    check("wr_ready_val", rdy_val, 2'b01);
    check("wr_cs_n", cs_v, 9'b100000001);
    check("wr_wr_n", wr_v, 9'b111000011);
    check("wr_rd_n", rd_v, 9'h1FF);
    check("wr_oe", oe_v, 9'b011111110);
    check("wr_busy_period", busy_v, 9'b011111110);
    check("wr_rsp_pulse", rsp_v, 9'b001000000);
    check("wr_rsp_val", rsp_val, 2'b01);
    check("wr_addr", addr_mid, 2'd2);
    check("wr_data", data_mid, 16'hBEEF);
    check("wr_rdata_kept", rdata_end, 16'h0);

    // Requester 1 reads register 0
    rq_valid = 2'b10; rq_write = 2'b00; rq_addr = 4'b0000; rd_inject = 16'h1234;
    window();
    check("rd_ready_val", rdy_val, 2'b10);
    check("rd_rd_n", rd_v, 9'b111000011);
    check("rd_wr_n", wr_v, 9'h1FF);
    check("rd_oe", oe_v, 9'h000);
    check("rd_cs_n", cs_v, 9'b100000001);
    check("rd_addr", addr_mid, 2'd0);
    check("rd_rsp_pulse", rsp_v, 9'b001000000);
    check("rd_rsp_val", rsp_val, 2'b10);
    check("rd_rdata", rdata_at_rsp, 16'h1234);
    check("rd_rdata_kept", rdata_end, 16'h1234);

    // Both requesters held: alternate grants with one IDLE cycle between accesses
    rq_valid = 2'b11; rq_write = 2'b11; rq_wdata = 32'h1111_2222;
    gcnt = 0; idle_cnt = 0;
    for (int i = 0; i < 4; i++) begin gcyc[i] = 0; gval[i] = 2'b00; end
    for (int c = 0; c < 60 && gcnt < 4; c++) begin
      if (gcnt > 0 && busy == 1'b0) idle_cnt++;
      if (rq_ready != 2'b00) begin
        gval[gcnt] = rq_ready;
        gcyc[gcnt] = c;
        gcnt++;
      end
      if (gcnt < 4) @(negedge clk);
    end
    rq_valid = 2'b00;
    check("rr_grants", gcnt, 4);
    check("rr_order", {gval[0], gval[1], gval[2], gval[3]}, 8'b01_10_01_10);
    for (int k = 0; k < 3; k++) check($sformatf("rr_period%0d", k), gcyc[k+1] - gcyc[k], 8);
    check("rr_idle_gaps", idle_cnt, 3);
    wait_idle("rr_idle");

    // Software reset in the 2nd STROBE cycle of a write
    rq_valid = 2'b01; rq_write = 2'b01; rq_addr = 4'b0001; rq_wdata = 32'h0000_5A5A;
    @(negedge clk);
    check("abort_ready", rq_ready, 2'b01);
    rq_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("abort_wr_low", hpi_wr_n, 0);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    check("abort_bus_idle", {hpi_wr_n, hpi_cs_n, hpi_rd_n, hpi_data_oe}, 4'b1110);
    check("abort_rst_n", hpi_rst_n, 0);
    check("abort_no_rsp", rsp_valid, 2'b00);
    low = 0; rdy_bad = 0;
    while (hpi_rst_n == 1'b0 && low < 50) begin
      low++;
      if (rsp_valid != 2'b00 || rq_ready != 2'b00) rdy_bad++;
      @(negedge clk);
    end
    check("abort_rst_len", low, 8);
    check("abort_quiet", rdy_bad, 0);
    @(negedge clk);
    // Pointer still names requester 0, so requester 1 wins the tie.
    check("abort_regrant", rq_ready, 2'b10);
    rq_valid = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rq_ready == 2'b00 && n < 20);
    check("pending_r0_served", rq_ready, 2'b01);
    rq_valid = 2'b00;
    wait_idle("abort_idle");

    // Interrupt synchronizer: two-cycle latency both ways
    hpi_int = 1'b1;
    @(negedge clk);
    check("irq_rise_1", irq, 0);
    @(negedge clk);
    check("irq_rise_2", irq, 1);
    hpi_int = 1'b0;
    @(negedge clk);
    check("irq_fall_1", irq, 1);
    @(negedge clk);
    check("irq_fall_2", irq, 0);

    check("strobe_exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hpi_access_sequencer.md
HPI_ACCESS_SEQUENCER -- requirements
Module: hpi_access_sequencer

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 4: cycles RD_N/WR_N held low per access (legal range 1..15).
REQ-002 SHALL have parameter HOLD_CYC, default 2: cycles after strobe release with CS_N low and write data held (legal range 1..15).
REQ-003 SHALL have parameter RST_CYC, default 200: cycles hpi_rst_n is held low after any reset (legal range 2..65535).
REQ-004 SHALL have port clk, input, 1 bit: single clock, 100 MHz domain, all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sw_rst, input, 1 bit: one-cycle pulse that restarts the CY7C67200 reset sequence.
REQ-007 SHALL have port rq_valid, input, 2 bits: per-requester access request, level, held until accepted.
REQ-008 SHALL have port rq_write, input, 2 bits: per-requester direction, 1 = write.
REQ-009 SHALL have port rq_addr, input, 4 bits: requester n uses bits [2n+1:2n].
REQ-010 SHALL have port rq_wdata, input, 32 bits: requester n uses bits [16n+15:16n].
REQ-011 SHALL have port rq_ready, output, 2 bits: one-cycle accept pulse to the granted requester.
REQ-012 SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-013 SHALL have port rsp_rdata, output, 16 bits: read data, valid while rsp_valid is set.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port irq, output, 1 bit: synchronized hpi_int level.
REQ-016 SHALL have port hpi_addr, output, 2 bits: HPI register select.
REQ-017 SHALL have port hpi_data_o, output, 16 bits: HPI write data.
REQ-018 SHALL have port hpi_data_oe, output, 1 bit: tristate enable for DATA.
REQ-019 SHALL have port hpi_data_i, input, 16 bits: HPI read data.
REQ-020 SHALL have ports hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, output, 1 bit each: active-low HPI controls.
REQ-021 SHALL have port hpi_int, input, 1 bit: asynchronous interrupt from the CY7C67200.

Function
REQ-022 FSM states SHALL be RST_HOLD, IDLE, SETUP, STROBE, HOLD.
REQ-023 RST_HOLD: hpi_rst_n=0 for RST_CYC cycles, then go to IDLE with hpi_rst_n=1; no grants in RST_HOLD.
REQ-024 IDLE: if any rq_valid, grant one requester, pulse its rq_ready, latch write/addr/wdata, go to SETUP.
REQ-025 Arbitration SHALL be round-robin: a sole requester wins; on a tie, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-026 SETUP, 1 cycle: hpi_cs_n=0 and hpi_addr driven; on writes hpi_data_oe=1 and hpi_data_o=latched wdata.
REQ-027 STROBE, STROBE_CYC cycles: hpi_rd_n=0 (read) or hpi_wr_n=0 (write); CS, address and data stay stable.
REQ-028 On reads, hpi_data_i SHALL be registered on the final STROBE cycle.
REQ-029 HOLD, HOLD_CYC cycles: strobes high, CS_N low, address and write data held, then go to IDLE.
REQ-030 On the first HOLD cycle, rsp_valid[owner] SHALL pulse for both reads and writes, with rsp_rdata = captured data on reads.
REQ-031 rsp_rdata SHALL keep its last value otherwise.
REQ-032 IDLE SHALL last at least one cycle between accesses, so one access takes 2+STROBE_CYC+HOLD_CYC cycles (8 at defaults).
REQ-033 hpi_rd_n and hpi_wr_n SHALL never both be low; hpi_data_oe SHALL be 0 whenever hpi_rd_n=0.
REQ-034 sw_rst in any state, including mid-access, SHALL abort to RST_HOLD on the next cycle.
REQ-035 On abort, strobes, CS_N and data_oe SHALL deassert in that cycle, no rsp_valid SHALL be issued, and the grant pointer SHALL be kept.
REQ-036 hpi_int SHALL pass through a 2-flop synchronizer to irq (2-cycle latency).
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 On reset: state=RST_HOLD, counter=0, hpi_rst_n=0, hpi_cs_n=hpi_rd_n=hpi_wr_n=1, hpi_data_oe=0, hpi_addr=0, hpi_data_o=0.
REQ-039 On reset: rq_ready=0, rsp_valid=0, rsp_rdata=0, busy=1, irq=0, synchronizer flops=0, grant pointer=1.

Structure
REQ-040 Package hpi_pkg SHALL hold the state enum and the HPI address constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3.
REQ-041 The round-robin grant logic SHALL be a sub-module hpi_rr_arbiter (2 requesters, with grant pointer).

Verification
REQ-042 Reset released, RST_CYC=8 -> hpi_rst_n low exactly 8 cycles, busy=1 throughout, no rq_ready while rq_valid=01.
REQ-043 Requester 0 writes 0xBEEF to addr 2 -> rq_ready=01 pulse; WR_N low 4 cycles; data_oe=1 from SETUP through HOLD; rsp_valid=01 on first HOLD cycle; 8-cycle period.
REQ-044 Requester 1 reads addr 0 with hpi_data_i=0x1234 during the final strobe cycle -> rsp_valid=10, rsp_rdata=0x1234, data_oe=0 throughout.
REQ-045 Both requesters held valid for 4 accesses -> grant order 0,1,0,1, with one IDLE cycle between accesses.
REQ-046 sw_rst pulse on the 2nd STROBE cycle of a write -> next cycle WR_N=1, CS_N=1, hpi_rst_n=0, no rsp_valid; the pending requester is served after RST_CYC.
REQ-047 hpi_int rises -> irq rises exactly 2 cycles later; hpi_int glitch shorter than one cycle is not required to be seen.
